// File: rtl/m_pkg.sv
// Constants and types shared by the MPU mux datapath: the mux itself and the
// scan sequencer that walks its select lines.
package m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    function automatic int lines_of(input int mux);
        return 1 << mux;
    endfunction

endpackage

// File: rtl/m_settle_timer.sv
// Per-line hold counter: counts 0..SETTLE while enabled and flags the cycle in
// which the current line has settled long enough to be sampled.
module m_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = (cnt_q == CNT_W'(SETTLE));

    // NOTE: cnt_d gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m_mux_scan.sv
// Scan sequencer: steps the mux select through every line, samples one bit per
// line after the settle time and hands the assembled word out over valid/ready.
module m_mux_scan
    import m_pkg::*;
#(
    parameter int MUX    = 2,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cont,
    input  logic                     line_bit,
    output logic [MUX-1:0]           select,
    output logic                     busy,
    output logic [lines_of(MUX)-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun
);

    localparam int LINES = lines_of(MUX);
    localparam logic [MUX-1:0] LAST_LINE = MUX'(LINES - 1);

    scan_state_t      state_q, state_d;
    logic [MUX-1:0]   select_q, select_d;
    logic [LINES-1:0] cap_q, cap_d;
    logic [LINES-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    // Counter is held at zero outside SCAN, so every entry into SCAN starts fresh.
    m_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != SCAN),
        .enable (state_q == SCAN),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        select_d    = select_q;
        cap_d       = cap_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = start && busy_q;

        case (state_q)
            IDLE: begin
                select_d = '0;
                if (start) begin
                    state_d = SCAN;
                    cap_d   = '0;
                end
            end
            SCAN: begin
                if (expire) begin
                    cap_d[select_q] = line_bit;
                    if (select_q == LAST_LINE) begin
                        out_data_d  = cap_d;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                        select_d    = '0;
                    end else begin
                        select_d = select_q + MUX'(1);
                    end
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    select_d    = '0;
                    if (cont) begin
                        state_d = SCAN;
                        cap_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            select_q    <= '0;
            cap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            select_q    <= select_d;
            cap_q       <= cap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign select    = select_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_m_mux_scan.sv
// Self-checking bench for m_mux_scan: three instances (SETTLE 1, 0, 3) in front
// of a behavioural 4:1 mux, checked against a timing/sampling reference model.
module tb_m_mux_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cont;
    logic       out_ready;
    logic [3:0] lines;

    logic       start_v [3];
    logic [1:0] sel     [3];
    logic       busy_w  [3];
    logic       valid   [3];
    logic       ovr     [3];
    logic [3:0] data    [3];
    logic       lb      [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign lb[0] = lines[sel[0]];
    assign lb[1] = lines[sel[1]];
    assign lb[2] = lines[sel[2]];

    m_mux_scan #(.MUX(2), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cont(cont), .line_bit(lb[0]),
        .select(sel[0]), .busy(busy_w[0]), .out_data(data[0]), .out_valid(valid[0]),
        .out_ready(out_ready), .overrun(ovr[0])
    );

    m_mux_scan #(.MUX(2), .SETTLE(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cont(cont), .line_bit(lb[1]),
        .select(sel[1]), .busy(busy_w[1]), .out_data(data[1]), .out_valid(valid[1]),
        .out_ready(out_ready), .overrun(ovr[1])
    );

    m_mux_scan #(.MUX(2), .SETTLE(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .cont(cont), .line_bit(lb[2]),
        .select(sel[2]), .busy(busy_w[2]), .out_data(data[2]), .out_valid(valid[2]),
        .out_ready(out_ready), .overrun(ovr[2])
    );

    function automatic int settle_of(input int idx);
        case (idx)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int idx);
        start_v[idx] = 1'b1;
        step();
        start_v[idx] = 1'b0;
    endtask

    // Returns the number of edges until out_valid is seen, or -1 on timeout.
    task automatic wait_valid(input int idx, input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (valid[idx] === 1'b1) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (sel[0] !== 2'd0)    $display("FAIL reset_select got=%0d exp=0", sel[0]); else n_pass++;
        n_checks++; if (valid[0] !== 1'b0)  $display("FAIL reset_valid got=%b exp=0", valid[0]); else n_pass++;
        n_checks++; if (data[0] !== 4'h0)   $display("FAIL reset_data got=%h exp=0", data[0]); else n_pass++;
        n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_w[0]); else n_pass++;
        n_checks++; if (ovr[0] !== 1'b0)    $display("FAIL reset_overrun got=%b exp=0", ovr[0]); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_scan();
        logic [1:0] exp_sel;
        lines     = 4'b1010;
        out_ready = 1'b1;
        cont      = 1'b0;
        pulse_start(0);
        for (int j = 0; j < 8; j++) begin
            exp_sel = 2'(j / 2);
            n_checks++; if (sel[0] !== exp_sel) $display("FAIL single_select edge=k+%0d got=%0d exp=%0d", j, sel[0], exp_sel); else n_pass++;
            n_checks++; if (valid[0] !== 1'b0)  $display("FAIL single_early_valid edge=k+%0d got=%b exp=0", j, valid[0]); else n_pass++;
            step();
        end
        n_checks++; if (valid[0] !== 1'b1)   $display("FAIL single_valid_k8 got=%b exp=1", valid[0]); else n_pass++;
        n_checks++; if (data[0] !== 4'b1010) $display("FAIL single_data got=%b exp=1010", data[0]); else n_pass++;
        step();
        n_checks++; if (valid[0] !== 1'b0)   $display("FAIL single_valid_drop got=%b exp=0", valid[0]); else n_pass++;
        n_checks++; if (busy_w[0] !== 1'b0)  $display("FAIL single_idle got=%b exp=0", busy_w[0]); else n_pass++;
    endtask

    task automatic test_backpressure();
        int c;
        lines     = 4'b0110;
        out_ready = 1'b0;
        cont      = 1'b0;
        pulse_start(0);
        wait_valid(0, 20, c);
        n_checks++; if (c != 8) $display("FAIL bp_latency got=%0d exp=8", c); else n_pass++;
        for (int n = 0; n < 5; n++) begin
            if (n == 2) lines = 4'b1111;
            n_checks++; if (valid[0] !== 1'b1)   $display("FAIL bp_valid stall=%0d got=%b exp=1", n, valid[0]); else n_pass++;
            n_checks++; if (data[0] !== 4'b0110) $display("FAIL bp_data stall=%0d got=%b exp=0110", n, data[0]); else n_pass++;
            n_checks++; if (sel[0] !== 2'd0)     $display("FAIL bp_select stall=%0d got=%0d exp=0", n, sel[0]); else n_pass++;
            step();
        end
        out_ready = 1'b1;
        step();
        n_checks++; if (valid[0] !== 1'b0)  $display("FAIL bp_release_valid got=%b exp=0", valid[0]); else n_pass++;
        n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL bp_release_busy got=%b exp=0", busy_w[0]); else n_pass++;
    endtask

    task automatic test_continuous();
        int c;
        logic [3:0] exp_word, next_word;
        cont      = 1'b1;
        out_ready = 1'b1;
        lines     = 4'b0001;
        exp_word  = 4'b0001;
        pulse_start(0);
        wait_valid(0, 20, c);
        n_checks++; if (c != 8) $display("FAIL cont_first_latency got=%0d exp=8", c); else n_pass++;
        for (int w = 0; w < 4; w++) begin
            n_checks++; if (data[0] !== exp_word) $display("FAIL cont_data word=%0d got=%b exp=%b", w, data[0], exp_word); else n_pass++;
            next_word = (exp_word == 4'b0001) ? 4'b1000 : 4'b0001;
            lines = next_word;
            if (w == 3) cont = 1'b0;
            step();
            n_checks++; if (valid[0] !== 1'b0) $display("FAIL cont_hs_valid word=%0d got=%b exp=0", w, valid[0]); else n_pass++;
            if (w < 3) begin
                n_checks++; if (sel[0] !== 2'd0 || busy_w[0] !== 1'b1)
                    $display("FAIL cont_restart word=%0d got sel=%0d busy=%b exp sel=0 busy=1", w, sel[0], busy_w[0]);
                else n_pass++;
                exp_word = next_word;
                wait_valid(0, 20, c);
                n_checks++; if (c != 8) $display("FAIL cont_spacing word=%0d got=%0d exp=8", w + 1, c); else n_pass++;
            end else begin
                n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL cont_exit_busy got=%b exp=0", busy_w[0]); else n_pass++;
            end
        end
    endtask

    task automatic test_settle();
        int c1, c2;
        logic [3:0] d1, d2;
        c1 = -1; c2 = -1; d1 = 'x; d2 = 'x;
        lines     = 4'b1100;
        out_ready = 1'b1;
        cont      = 1'b0;
        start_v[1] = 1'b1;
        start_v[2] = 1'b1;
        step();
        start_v[1] = 1'b0;
        start_v[2] = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (valid[1] === 1'b1 && c1 < 0) begin c1 = c; d1 = data[1]; end
            if (valid[2] === 1'b1 && c2 < 0) begin c2 = c; d2 = data[2]; end
        end
        n_checks++; if (c1 != 4)        $display("FAIL settle0_latency got=%0d exp=4", c1); else n_pass++;
        n_checks++; if (d1 !== 4'b1100) $display("FAIL settle0_data got=%b exp=1100", d1); else n_pass++;
        n_checks++; if (c2 != 16)       $display("FAIL settle3_latency got=%0d exp=16", c2); else n_pass++;
        n_checks++; if (d2 !== 4'b1100) $display("FAIL settle3_data got=%b exp=1100", d2); else n_pass++;
        n_checks++; if (busy_w[1] !== 1'b0 || busy_w[2] !== 1'b0)
            $display("FAIL settle_idle got=%b%b exp=00", busy_w[1], busy_w[2]);
        else n_pass++;
    endtask

    task automatic test_overrun_reset();
        logic seen;
        lines     = 4'b1010;
        out_ready = 1'b1;
        cont      = 1'b0;
        pulse_start(0);
        step();
        step();
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        n_checks++; if (ovr[0] !== 1'b1)    $display("FAIL overrun_pulse got=%b exp=1", ovr[0]); else n_pass++;
        n_checks++; if (sel[0] !== 2'd1)    $display("FAIL overrun_no_restart got=%0d exp=1", sel[0]); else n_pass++;
        step();
        n_checks++; if (ovr[0] !== 1'b0)    $display("FAIL overrun_one_cycle got=%b exp=0", ovr[0]); else n_pass++;
        n_checks++; if (sel[0] !== 2'd2)    $display("FAIL overrun_progress got=%0d exp=2", sel[0]); else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++; if (sel[0] !== 2'd0 || valid[0] !== 1'b0 || data[0] !== 4'h0 || busy_w[0] !== 1'b0 || ovr[0] !== 1'b0)
            $display("FAIL midscan_reset got sel=%0d valid=%b data=%h busy=%b ovr=%b exp all 0",
                     sel[0], valid[0], data[0], busy_w[0], ovr[0]);
        else n_pass++;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (valid[0] === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0)      $display("FAIL aborted_scan_valid got=%b exp=0", seen); else n_pass++;
        n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL aborted_scan_busy got=%b exp=0", busy_w[0]); else n_pass++;
    endtask

    task automatic test_start_at_handshake();
        int c;
        lines     = 4'b0101;
        out_ready = 1'b0;
        cont      = 1'b0;
        pulse_start(0);
        wait_valid(0, 20, c);
        n_checks++; if (c != 8) $display("FAIL hs_start_latency got=%0d exp=8", c); else n_pass++;
        out_ready  = 1'b1;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        n_checks++; if (ovr[0] !== 1'b1)    $display("FAIL hs_start_overrun got=%b exp=1", ovr[0]); else n_pass++;
        n_checks++; if (busy_w[0] !== 1'b0 || valid[0] !== 1'b0)
            $display("FAIL hs_start_idle got busy=%b valid=%b exp 0 0", busy_w[0], valid[0]);
        else n_pass++;
        step();
        n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL hs_start_ignored got=%b exp=0", busy_w[0]); else n_pass++;
    endtask

    // Lines change every cycle; the model picks, for each line i, the pattern
    // present at the sampling edge (i+1)*(SETTLE+1) after start.
    task automatic test_random_scans();
        logic [3:0] hist [0:16];
        logic [3:0] model, tmp;
        logic       early;
        int         s, lat, r;
        for (int idx = 0; idx < 3; idx++) begin
            for (int it = 0; it < 4; it++) begin
                s   = settle_of(idx);
                lat = 4 * (s + 1);
                out_ready = 1'b0;
                cont      = 1'b0;
                early     = 1'b0;
                lines     = 4'($urandom);
                pulse_start(idx);
                for (int e = 1; e <= lat; e++) begin
                    lines   = 4'($urandom);
                    hist[e] = lines;
                    step();
                    if (e < lat && valid[idx] === 1'b1) early = 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    tmp      = hist[(i + 1) * (s + 1)];
                    model[i] = tmp[i];
                end
                n_checks++; if (early !== 1'b0 || valid[idx] !== 1'b1)
                    $display("FAIL rand_valid dut=%0d it=%0d got early=%b valid=%b exp 0 1", idx, it, early, valid[idx]);
                else n_pass++;
                n_checks++; if (data[idx] !== model)
                    $display("FAIL rand_data dut=%0d it=%0d got=%b exp=%b", idx, it, data[idx], model);
                else n_pass++;
                r = $urandom_range(0, 3);
                for (int k = 0; k < r; k++) begin
                    lines = 4'($urandom);
                    step();
                    n_checks++; if (data[idx] !== model || valid[idx] !== 1'b1)
                        $display("FAIL rand_stall dut=%0d it=%0d got=%b/%b exp=%b/1", idx, it, data[idx], valid[idx], model);
                    else n_pass++;
                end
                out_ready = 1'b1;
                step();
                n_checks++; if (valid[idx] !== 1'b0 || busy_w[idx] !== 1'b0)
                    $display("FAIL rand_release dut=%0d it=%0d got valid=%b busy=%b exp 0 0", idx, it, valid[idx], busy_w[idx]);
                else n_pass++;
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cont       = 1'b0;
        out_ready  = 1'b0;
        lines      = 4'h0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        start_v[2] = 1'b0;
        test_reset();
        test_single_scan();
        test_backpressure();
        test_continuous();
        test_settle();
        test_overrun_reset();
        test_start_at_handshake();
        test_random_scans();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
